// File: rtl/disp_arbiter_pkg.sv
// rtl/disp_arbiter_pkg.sv - shared display types: arbiter state and owner IDs
package disp_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_A = 1'b0,
      OWNER_B = 1'b1
   } owner_t;

   localparam logic [3:0] BLANK_ALL = 4'b1111;

endpackage

// File: rtl/disp_arbiter_zero_blank.sv
// rtl/disp_arbiter_zero_blank.sv - leading-zero digit blank mask for a 4-nibble value
module zero_blank (
   input  logic [15:0] i_data,
   output logic [3:0]  o_blank
);

   // Digit 0 is never blanked so a zero value still shows a single "0".
   assign o_blank = {i_data[15:12] == 4'h0,
                     i_data[15:8]  == 8'h00,
                     i_data[15:4]  == 12'h000,
                     1'b0};

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - two-requester 7-segment display arbiter with scan prescaler and hold time
module disp_arbiter
   import disp_arbiter_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int SCAN_HZ    = 1000,
   parameter int HOLD_TICKS = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] data_a,
   input  logic        req_b,
   input  logic [15:0] data_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [15:0] disp_val,
   output logic [3:0]  disp_blank,
   output logic        scan_tick
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int HW  = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);

   logic [PW-1:0] r_presc;
   logic          w_tick;
   state_t        r_state;
   state_t        w_next;
   owner_t        r_last;
   owner_t        w_last_next;
   logic [HW-1:0] r_hold;
   logic          w_expired;
   logic [15:0]   w_sel_data;
   logic [3:0]    w_blank;
   logic          r_gnt_a;
   logic          r_gnt_b;
   logic [15:0]   r_val;
   logic [3:0]    r_blank;

   assign w_tick    = (r_presc == PRESC_LAST);
   assign w_expired = (r_hold == HOLD_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_last_next = r_last;
      case (r_state)
         ST_IDLE: begin
            if (req_a && (!req_b || r_last == OWNER_B)) begin
               w_next = ST_OWN_A;
            end else if (req_b) begin
               w_next = ST_OWN_B;
            end
         end
         ST_OWN_A: begin
            if (!req_a) begin
               w_next      = ST_IDLE;
               w_last_next = OWNER_A;
            end else if (req_b && w_expired) begin
               w_next      = ST_OWN_B;
               w_last_next = OWNER_A;
            end
         end
         ST_OWN_B: begin
            if (!req_b) begin
               w_next      = ST_IDLE;
               w_last_next = OWNER_B;
            end else if (req_a && w_expired) begin
               w_next      = ST_OWN_A;
               w_last_next = OWNER_B;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Outputs follow the next state so data and blank line up with the grant edge.
   assign w_sel_data = (w_next == ST_OWN_B) ? data_b : data_a;

   zero_blank u_zero_blank (
      .i_data  (w_sel_data),
      .o_blank (w_blank)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= OWNER_B;
         r_hold  <= '0;
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         r_val   <= 16'h0000;
         r_blank <= BLANK_ALL;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_next;
         if (w_next != r_state) begin
            r_hold <= '0;
         end else if (r_state != ST_IDLE && w_tick && !w_expired) begin
            r_hold <= r_hold + 1'b1;
         end
         r_gnt_a <= (w_next == ST_OWN_A);
         r_gnt_b <= (w_next == ST_OWN_B);
         if (w_next != ST_IDLE) begin
            r_val <= w_sel_data;
         end
         r_blank <= (w_next == ST_IDLE) ? BLANK_ALL : w_blank;
      end
   end

   assign gnt_a      = r_gnt_a;
   assign gnt_b      = r_gnt_b;
   assign disp_val   = r_val;
   assign disp_blank = r_blank;
   assign scan_tick  = w_tick;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - randomized scoreboard bench for disp_arbiter against a reference model
module tb_disp_arbiter;

   localparam int CLK_HZ = 1000;
   localparam int SCAN_HZ = 250;
   localparam int HOLD = 2;
   localparam int DIV = CLK_HZ / SCAN_HZ;

   typedef struct packed {
      logic        ga;
      logic        gb;
      logic [15:0] val;
      logic [3:0]  blank;
      logic        tick;
   } obs_t;

   logic        clk;
   logic        rst;
   logic        req_a;
   logic [15:0] data_a;
   logic        req_b;
   logic [15:0] data_b;
   logic        gnt_a;
   logic        gnt_b;
   logic [15:0] disp_val;
   logic [3:0]  disp_blank;
   logic        scan_tick;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_out = 0;

   // owner: 0 none, 1 A, 2 B
   int          m_owner = 0;
   int          m_last = 2;
   int          m_held = 0;
   int          m_edges = 0;
   logic [15:0] m_val = 16'h0000;
   logic [3:0]  m_blank = 4'b1111;

   disp_arbiter #(
      .CLK_HZ     (CLK_HZ),
      .SCAN_HZ    (SCAN_HZ),
      .HOLD_TICKS (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .data_a     (data_a),
      .req_b      (req_b),
      .data_b     (data_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .disp_val   (disp_val),
      .disp_blank (disp_blank),
      .scan_tick  (scan_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] blank_of(input logic [15:0] d);
      int lz;
      logic [3:0] b;
      lz = 0;
      while (lz < 4 && d[15 - 4*lz -: 4] == 4'h0) lz++;
      b = 4'b0000;
      for (int i = 1; i < 4; i++) if (i >= 4 - lz) b[i] = 1'b1;
      return b;
   endfunction

   task automatic step(input logic r, input logic ra, input logic [15:0] da,
                       input logic rb, input logic [15:0] db);
      int   nxt;
      bit   tick_before;
      obs_t e;
      @(negedge clk);
      rst = r; req_a = ra; data_a = da; req_b = rb; data_b = db;
      if (r) begin
         m_owner = 0; m_last = 2; m_held = 0; m_edges = 0;
         m_val = 16'h0000; m_blank = 4'b1111;
      end else begin
         tick_before = ((m_edges % DIV) == DIV - 1);
         nxt = m_owner;
         if (m_owner == 0) begin
            if (ra && rb) nxt = (m_last == 2) ? 1 : 2;
            else if (ra) nxt = 1;
            else if (rb) nxt = 2;
         end else begin
            bit mine  = (m_owner == 1) ? ra : rb;
            bit other = (m_owner == 1) ? rb : ra;
            if (!mine) begin
               nxt = 0; m_last = m_owner;
            end else if (other && m_held >= HOLD) begin
               nxt = 3 - m_owner; m_last = m_owner;
            end
         end
         if (nxt != m_owner) m_held = 0;
         else if (m_owner != 0 && tick_before && m_held < HOLD) m_held++;
         m_owner = nxt;
         m_edges++;
         if (m_owner == 1) begin m_val = da; m_blank = blank_of(da); end
         else if (m_owner == 2) begin m_val = db; m_blank = blank_of(db); end
         else m_blank = 4'b1111;
      end
      e.ga    = (m_owner == 1);
      e.gb    = (m_owner == 2);
      e.val   = m_val;
      e.blank = m_blank;
      e.tick  = !r && ((m_edges % DIV) == DIV - 1);
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      obs_t e;
      obs_t g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{gnt_a, gnt_b, disp_val, disp_blank, scan_tick};
         n_checks++;
         n_out++;
         if (g !== e)
            $display("FAIL out%0d got ga=%b gb=%b val=%h blank=%b tick=%b want ga=%b gb=%b val=%h blank=%b tick=%b",
                     n_out, g.ga, g.gb, g.val, g.blank, g.tick, e.ga, e.gb, e.val, e.blank, e.tick);
         else
            n_pass++;
      end
   end

   function automatic logic [15:0] rand_data();
      logic [31:0] d;
      int lz;
      d = $urandom;
      lz = $urandom_range(0, 4);
      return 16'(d[15:0] >> (4 * lz));
   endfunction

   initial begin
      logic ra;
      logic rb;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 16'h0; data_b = 16'h0;
      // Reset then idle: ticks at 4, 8, 12.
      repeat (3) step(1, 0, 16'h1234, 0, 16'h5678);
      repeat (12) step(0, 0, 16'h1234, 0, 16'h5678);
      // Single A request.
      repeat (4) step(0, 1, 16'h00A5, 0, 16'h0);
      step(0, 0, 16'h00A5, 0, 16'h0);
      // Tie after reset, release, round-robin.
      step(1, 0, 16'h0, 0, 16'h0);
      repeat (3) step(0, 1, 16'h0A11, 1, 16'hB022);
      repeat (3) step(0, 0, 16'h0A11, 1, 16'hB022);
      repeat (2) step(0, 0, 16'h0A11, 0, 16'hB022);
      repeat (3) step(0, 1, 16'h0A11, 1, 16'hB022);
      // Preemption after hold expires.
      step(1, 0, 16'h0, 0, 16'h0);
      step(0, 1, 16'h0123, 0, 16'h4567);
      repeat (14) step(0, 1, 16'h0123, 1, 16'h4567);
      // B owns zero data, reset mid-ownership.
      step(1, 0, 16'h0, 0, 16'h0);
      repeat (3) step(0, 0, 16'hFFFF, 1, 16'h0000);
      step(1, 0, 16'hFFFF, 1, 16'h0000);
      repeat (2) step(0, 0, 16'hFFFF, 0, 16'h0000);
      // Simultaneous release and other request.
      step(0, 1, 16'h000C, 0, 16'h0);
      step(0, 0, 16'h000C, 1, 16'h0D00);
      repeat (3) step(0, 0, 16'h000C, 1, 16'h0D00);
      // Random traffic.
      ra = 1'b0; rb = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) ra = ~ra;
         if ($urandom_range(0, 7) == 0) rb = ~rb;
         step(($urandom_range(0, 99) == 0), ra, rand_data(), rb, rand_data());
      end
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, digit-scan tick rate in Hz; DIV = CLK_HZ/SCAN_HZ, integer, >= 2.
REQ-003 Parameter HOLD_TICKS, default 500, minimum ownership in scan ticks before preemption, >= 1.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 req_a  in  1  requester A wants the display (level).
REQ-007 data_a  in  16  requester A value, 4 hex nibbles.
REQ-008 req_b  in  1  requester B wants the display (level).
REQ-009 data_b  in  16  requester B value.
REQ-010 gnt_a  out  1  A owns the display.
REQ-011 gnt_b  out  1  B owns the display.
REQ-012 disp_val  out  16  value to the 7-segment scan driver.
REQ-013 disp_blank  out  4  per-digit blank mask, bit i blanks digit i (bit 0 = least significant nibble).
REQ-014 scan_tick  out  1  one-cycle pulse every DIV clocks; clock enable for the scan driver.

Function
REQ-015 The prescaler counts 0..DIV-1; scan_tick is high for exactly the cycle in which the count equals DIV-1; the count wraps to 0 on that cycle.
REQ-016 FSM states: IDLE, OWN_A, OWN_B; gnt_a = (state==OWN_A), gnt_b = (state==OWN_B), both registered, never high together.
REQ-017 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the requester not in last_owner; neither -> stay IDLE.
REQ-018 Grant latency: gnt is high on the first clock edge after req is sampled high in IDLE (1 cycle).
REQ-019 OWN_X with req_X low -> IDLE next cycle, regardless of hold count; last_owner <= X.
REQ-020 OWN_X with req_X high, other requester high, hold expired -> OWN_other directly in one cycle (no IDLE gap); last_owner <= X.
REQ-021 Hold counter: cleared on every state entry, incremented on scan_tick while in OWN_A/OWN_B, saturates at HOLD_TICKS; expired = (count == HOLD_TICKS).
REQ-022 Simultaneous release and other request in the same cycle -> IDLE first, then REQ-017 applies (2-cycle handover).
REQ-023 disp_val is registered: in OWN_X it loads data_X every cycle; in IDLE it holds its last value.
REQ-024 disp_blank is registered: in IDLE it is 4'b1111; in OWN_X, bit i (i = 1..3) is set iff nibbles 3..i of data_X are all zero; bit 0 is always 0 (value 0 shows a single "0").
REQ-025 The prescaler runs freely in every state; arbitration never stalls scan_tick.

Reset
REQ-026 While rst is high: state = IDLE, gnt_a = gnt_b = 0, disp_val = 16'h0000, disp_blank = 4'b1111, scan_tick = 0, prescaler = 0, hold = 0, last_owner = B (so A wins the first tie).
REQ-027 Reset asserted mid-ownership drops the grant on the next edge; outputs take their reset values with no partial handover.
REQ-028 After rst deasserts, the first scan_tick occurs DIV cycles later.

Structure
REQ-029 State encoding (IDLE, OWN_A, OWN_B) and the owner-ID encoding (A = 0, B = 1) are defined in the shared display package.
REQ-030 The leading-zero blank logic is a sub-module, zero_blank (16-bit in, 4-bit mask out); everything else lives in disp_arbiter.

Verification (CLK_HZ=1000, SCAN_HZ=250 -> DIV=4, HOLD_TICKS=2)
REQ-031 rst for 3 cycles, then idle for 12 cycles -> scan_tick pulses at cycles 4, 8, 12 after release; gnt_a = gnt_b = 0; disp_blank = 4'b1111; disp_val = 16'h0000.
REQ-032 req_a=1, data_a=16'h00A5 -> gnt_a rises 1 cycle later; disp_val = 16'h00A5; disp_blank = 4'b1100.
REQ-033 req_a and req_b rise together after reset -> A is granted; A drops req -> IDLE for one cycle, then gnt_b; B drops and both re-request -> A is granted (round-robin).
REQ-034 A owns, req_b rises immediately -> no switch until 2 scan_ticks after A's grant; on the next edge gnt_a=0, gnt_b=1 in the same cycle; disp_val = data_b.
REQ-035 B owns, data_b=16'h0000 -> disp_blank = 4'b1110; assert rst for 1 cycle mid-ownership -> gnt_b=0, disp_val=16'h0000, disp_blank=4'b1111 on the next edge.
